// File: rtl/speed_pkg.sv
// Shared types and defaults for the speed meter: FSM states, default wheel
// factor and clamp ceiling, and the legal range of the averaging depth.
package speed_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FREE = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_RES  = 3'd4,
        DONE_ZERO = 3'd5
    } state_t;

    // Wheel factor in Q8.8, roughly 73.728.
    localparam logic [15:0] DEF_CONST     = 16'h49BA;
    localparam int          DEF_SPEED_MAX = 99;

    // Averaging over 2..8 periods is supported.
    function automatic bit avg_log2_ok(input int v);
        return (v >= 1) && (v <= 3);
    endfunction

endpackage

// File: rtl/speed_meter_if.sv
// Divider handshake bundle. The speed meter is the master: it drives the
// operands and the one-cycle start pulse; the shared divider answers with
// busy, a one-cycle ready and the quotient. Handshake: start is honoured only
// when busy is low; busy high acknowledges the start; ready marks the cycle
// in which dividerres holds the result.
interface speed_meter_if #(
    parameter int WIDTH = 16
);
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] dividerres;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             div_start;

    modport master (
        output dividend, divisor, div_start,
        input  busy, ready, dividerres
    );

    modport slave (
        input  dividend, divisor, div_start,
        output busy, ready, dividerres
    );
endinterface

// File: rtl/period_avg.sv
// Moving average of reed periods: ring buffer of the last 2^AVG_LOG2 periods,
// running sum, fill level and the armed flag that discards the first
// (partial) period after reset or a stall.
module period_avg #(
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_reed,
    input  logic [WIDTH-1:0] i_period,
    input  logic             i_clear,
    output logic             o_store,
    output logic [WIDTH-1:0] o_avg,
    output logic             o_no_data
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = WIDTH + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [WIDTH-1:0]    r_ring [DEPTH];
    logic [AVG_LOG2-1:0] r_wr_ptr;
    logic [SUM_W-1:0]    r_sum;
    logic [FILL_W-1:0]   r_fill;
    logic                r_armed;
    logic [WIDTH-1:0]    r_latest;

    logic [WIDTH-1:0]    w_oldest;
    logic [SUM_W-1:0]    w_sum_next;
    logic                w_full;
    logic [WIDTH-1:0]    w_avg;

    // Slots not yet written hold zero, so the oldest entry can always be
    // subtracted from the sum without checking the fill level.
    assign w_oldest   = r_ring[r_wr_ptr];
    assign w_sum_next = r_sum - SUM_W'(w_oldest) + SUM_W'(i_period);
    assign w_full     = (r_fill == FILL_W'(DEPTH));
    assign w_avg      = w_full ? r_sum[SUM_W-1:AVG_LOG2] : r_latest;

    assign o_store    = i_reed && r_armed && !i_clear;
    assign o_avg      = w_avg;
    assign o_no_data  = (r_fill == '0) || (w_avg == '0);

    // Ring, sum and fill update on stored periods; a stall wipes everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ring[i] <= '0;
            r_wr_ptr <= '0;
            r_sum    <= '0;
            r_fill   <= '0;
            r_armed  <= 1'b0;
            r_latest <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) r_ring[i] <= '0;
            r_wr_ptr <= '0;
            r_sum    <= '0;
            r_fill   <= '0;
            r_latest <= '0;
            // A reed coinciding with the stall starts a fresh period.
            r_armed  <= i_reed;
        end else if (i_reed) begin
            if (r_armed) begin
                r_ring[r_wr_ptr] <= i_period;
                r_wr_ptr         <= r_wr_ptr + AVG_LOG2'(1);
                r_sum            <= w_sum_next;
                r_latest         <= i_period;
                if (!w_full) r_fill <= r_fill + FILL_W'(1);
            end else begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/speed_meter.sv
// Bike-computer speed block: counts time-base ticks between reed pulses,
// detects stalls, and on request computes (circ*CONST)/avg_period on the
// shared divider, clamping the quotient to SPEED_MAX.
module speed_meter
    import speed_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          SPEED_W   = 12,
    parameter logic [15:0] CONST     = DEF_CONST,
    parameter int          AVG_LOG2  = 2,
    parameter int          TIMEOUT   = (1 << WIDTH) - 1,
    parameter int          SPEED_MAX = DEF_SPEED_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               reed,
    input  logic [7:0]         circ,
    input  logic               start,
    speed_meter_if.master      div,
    output logic [SPEED_W-1:0] speed,
    output logic               valid,
    output logic               stalled
);

    if (!avg_log2_ok(AVG_LOG2)) begin : g_avg_log2_illegal
        $error("speed_meter: AVG_LOG2 must be in 1..3");
    end

    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);

    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_numerator;
    logic               r_stalled;
    state_t             r_state;
    state_t             w_next;
    logic [SPEED_W-1:0] r_speed;
    logic               r_valid;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_div_start;

    logic [WIDTH+7:0]   w_cico;
    logic               w_at_timeout;
    logic               w_store;
    logic [WIDTH-1:0]   w_avg;
    logic               w_no_data;
    logic [SPEED_W-1:0] w_clamped;

    // circ*CONST is Q16.8; the integer part is the divider numerator.
    assign w_cico       = (WIDTH + 8)'(circ) * (WIDTH + 8)'(CONST);
    assign w_at_timeout = (r_cnt == TIMEOUT_V);
    // Clamp looks at every quotient bit, not just the ones that fit in speed.
    assign w_clamped    = (div.dividerres > WIDTH'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                               : div.dividerres[SPEED_W-1:0];

    period_avg #(
        .WIDTH    (WIDTH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_period_avg (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_reed    (reed),
        .i_period  (r_cnt),
        .i_clear   (w_at_timeout),
        .o_store   (w_store),
        .o_avg     (w_avg),
        .o_no_data (w_no_data)
    );

    // Registered numerator, refreshed every cycle from the current circ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_numerator <= '0;
        else      r_numerator <= WIDTH'(w_cico >> 8);
    end

    // Tick counter: reed restarts it (even with a tick in the same cycle), saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         r_cnt <= '0;
        else if (reed)                    r_cnt <= '0;
        else if (en && r_cnt < TIMEOUT_V) r_cnt <= r_cnt + WIDTH'(1);
    end

    // Stall flag: set once the counter saturates, cleared by the next stored period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              r_stalled <= 1'b0;
        else if (w_at_timeout) r_stalled <= 1'b1;
        else if (w_store)      r_stalled <= 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // FSM next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (start) w_next = WAIT_FREE;
            WAIT_FREE: begin
                if (w_no_data)     w_next = DONE_ZERO;
                else if (!div.busy) w_next = ISSUE;
            end
            ISSUE:     w_next = WAIT_ACK;
            WAIT_ACK:  if (div.busy)  w_next = WAIT_RES;
            WAIT_RES:  if (div.ready) w_next = IDLE;
            DONE_ZERO: w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Datapath registers: operand latch and start pulse in ISSUE, result capture at the end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_speed     <= '0;
            r_valid     <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                IDLE:      if (start) r_valid <= 1'b0;
                ISSUE: begin
                    r_dividend  <= r_numerator;
                    r_divisor   <= w_avg;
                    r_div_start <= 1'b1;
                end
                WAIT_RES: begin
                    if (div.ready) begin
                        r_speed <= w_clamped;
                        r_valid <= 1'b1;
                    end
                end
                DONE_ZERO: begin
                    r_speed <= '0;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign div.dividend  = r_dividend;
    assign div.divisor   = r_divisor;
    assign div.div_start = r_div_start;
    assign speed         = r_speed;
    assign valid         = r_valid;
    assign stalled       = r_stalled;

endmodule

// File: tb/tb_speed_meter.sv
// Directed bench for speed_meter. A small model tracks the stored periods and
// predicts operands and clamped speed; a compare process checks every start
// pulse and every fresh result against it, and the sequence adds literal
// expectations worked out by hand.
module tb_speed_meter;

    localparam int WIDTH     = 16;
    localparam int SPEED_W   = 12;
    localparam int TIMEOUT   = 4000;
    localparam int SPEED_MAX = 99;
    localparam int K_CONST   = 18874;  // 0x49BA

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               reed = 1'b0;
    logic [7:0]         circ = 8'd0;
    logic               start = 1'b0;
    logic [SPEED_W-1:0] speed;
    logic               valid;
    logic               stalled;

    speed_meter_if #(.WIDTH(WIDTH)) u_if();

    speed_meter #(
        .WIDTH     (WIDTH),
        .SPEED_W   (SPEED_W),
        .CONST     (16'h49BA),
        .AVG_LOG2  (2),
        .TIMEOUT   (TIMEOUT),
        .SPEED_MAX (SPEED_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .reed    (reed),
        .circ    (circ),
        .start   (start),
        .div     (u_if),
        .speed   (speed),
        .valid   (valid),
        .stalled (stalled)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state.
    int m_hist[$];
    bit m_armed = 1'b0;
    int exp_dividend = 0;
    int exp_divisor = 0;
    int exp_quot = 0;
    int exp_speed = 0;

    // Observations from the compare process.
    int   n_div_start = 0;
    int   seen_dividend = 0;
    int   seen_divisor = 0;
    logic prev_valid = 1'b0;
    logic prev_div_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: average of the last four stored periods, or the latest one while
    // fewer than four exist; no periods or a zero average gives speed 0.
    task automatic model_expect(input int override);
        int n;
        int avg;
        n = m_hist.size();
        exp_dividend = (int'(circ) * K_CONST) / 256;
        if (n == 0)      avg = 0;
        else if (n >= 4) avg = (m_hist[n-1] + m_hist[n-2] + m_hist[n-3] + m_hist[n-4]) / 4;
        else             avg = m_hist[n-1];
        exp_divisor = avg;
        if (override >= 0)  exp_quot = override;
        else if (avg != 0)  exp_quot = exp_dividend / avg;
        else                exp_quot = 0;
        if (avg == 0)                  exp_speed = 0;
        else if (exp_quot > SPEED_MAX) exp_speed = SPEED_MAX;
        else                           exp_speed = exp_quot;
    endtask

    // n ticks, then a reed together with a tick; the DUT should record n.
    task automatic do_period(input int n);
        en = 1'b1;
        reed = 1'b0;
        repeat (n) cyc();
        reed = 1'b1;
        cyc();
        reed = 1'b0;
        en = 1'b0;
        if (m_armed) begin
            m_hist.push_back(n);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
        end else begin
            m_armed = 1'b1;
        end
    endtask

    task automatic request(input int override);
        model_expect(override);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_div_start(output bit ok);
        int t;
        t = 0;
        while (u_if.div_start !== 1'b1 && t < 40) begin
            cyc();
            t++;
        end
        ok = (u_if.div_start === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL div_start_timeout: got no pulse expected one within 40 cycles");
        end
    endtask

    // Divider stand-in: acknowledge with busy, then return the model quotient.
    task automatic serve(input int busy_cycles, input bit inject_start);
        bit ok;
        wait_div_start(ok);
        if (ok) begin
            u_if.busy = 1'b1;
            cyc();
            for (int i = 0; i < busy_cycles; i++) begin
                if (inject_start && i == 0) start = 1'b1;
                cyc();
                start = 1'b0;
            end
            u_if.busy = 1'b0;
            u_if.ready = 1'b1;
            u_if.dividerres = exp_quot[WIDTH-1:0];
            cyc();
            u_if.ready = 1'b0;
            u_if.dividerres = '0;
        end
    endtask

    // Compare process: operands on every start pulse, speed on every fresh result.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (u_if.div_start === 1'b1) begin
                n_div_start++;
                seen_dividend = int'(u_if.dividend);
                seen_divisor  = int'(u_if.divisor);
                check("dividend", u_if.dividend, exp_dividend);
                check("divisor", u_if.divisor, exp_divisor);
                if (prev_div_start === 1'b1) check("div_start_width", 32'd2, 32'd1);
            end
            if (valid === 1'b1 && prev_valid !== 1'b1) check("speed", speed, exp_speed);
        end
        prev_valid     = valid;
        prev_div_start = u_if.div_start;
    end

    // Watchdog.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test expected finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        int nds;
        int nlow;
        bit ok;
        u_if.busy = 1'b0;
        u_if.ready = 1'b0;
        u_if.dividerres = '0;
        circ = 8'd200;
        rst = 1'b0;
        repeat (3) cyc();
        check("rst_speed", speed, 0);
        check("rst_valid", valid, 0);
        check("rst_stalled", stalled, 0);
        check("rst_div_start", u_if.div_start, 0);
        check("rst_dividend", u_if.dividend, 0);
        check("rst_divisor", u_if.divisor, 0);
        rst = 1'b1;
        cyc();

        // Five reeds 500 ticks apart: the first only arms.
        repeat (5) do_period(500);
        check("run_not_stalled", stalled, 0);
        request(-1);
        serve(3, 1'b0);
        check("t1_dividend_lit", seen_dividend, 14745);
        check("t1_divisor_lit", seen_divisor, 500);
        check("t1_speed_lit", speed, 29);
        check("t1_valid", valid, 1);

        // Mixed periods average to 500.
        do_period(400);
        do_period(400);
        do_period(600);
        do_period(600);
        request(-1);
        serve(2, 1'b0);
        check("mix_divisor_lit", seen_divisor, 500);
        check("mix_speed_lit", speed, 29);

        // Short periods: quotient 147 clamps to 99.
        repeat (4) do_period(100);
        request(-1);
        serve(4, 1'b0);
        check("fast_divisor_lit", seen_divisor, 100);
        check("fast_speed_clamp", speed, 99);

        // Quotient with upper bits set also clamps.
        request(16'h1005);
        serve(1, 1'b0);
        check("upper_bit_clamp", speed, 99);

        // Divider busy at request time: no start until busy falls; a start
        // during WAIT_RES is ignored.
        u_if.busy = 1'b1;
        nds = n_div_start;
        request(-1);
        repeat (20) cyc();
        check("busy_hold_no_start", n_div_start, nds);
        u_if.busy = 1'b0;
        serve(2, 1'b1);
        check("busy_one_start", n_div_start, nds + 1);
        check("busy_speed", speed, 99);
        nlow = 0;
        repeat (6) begin
            cyc();
            if (valid !== 1'b1) nlow++;
        end
        check("ignored_start_valid_hold", nlow, 0);
        check("ignored_start_no_issue", n_div_start, nds + 1);

        // Stall: no reed for TIMEOUT ticks.
        en = 1'b1;
        repeat (TIMEOUT - 1) cyc();
        check("stall_edge_before", stalled, 0);
        repeat (2) cyc();
        check("stall_set", stalled, 1);
        en = 1'b0;
        m_hist.delete();
        m_armed = 1'b0;
        nds = n_div_start;
        request(-1);
        check("zero_path_valid_c1", valid, 0);
        cyc();
        check("zero_path_valid_c2", valid, 0);
        cyc();
        check("zero_path_valid", valid, 1);
        check("zero_path_speed", speed, 0);
        check("zero_path_no_issue", n_div_start, nds);

        // First reed after a stall only arms; the second stores 300.
        do_period(100);
        check("stall_after_arm", stalled, 1);
        do_period(300);
        check("stall_cleared", stalled, 0);
        request(-1);
        serve(2, 1'b0);
        check("single_divisor_lit", seen_divisor, 300);
        check("single_speed_lit", speed, 49);

        // Reset while waiting for the result.
        request(-1);
        wait_div_start(ok);
        u_if.busy = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("midrst_speed", speed, 0);
        check("midrst_valid", valid, 0);
        check("midrst_stalled", stalled, 0);
        check("midrst_div_start", u_if.div_start, 0);
        check("midrst_dividend", u_if.dividend, 0);
        check("midrst_divisor", u_if.divisor, 0);
        u_if.busy = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        u_if.ready = 1'b1;
        u_if.dividerres = 16'd49;
        cyc();
        u_if.ready = 1'b0;
        u_if.dividerres = '0;
        repeat (3) cyc();
        check("late_ready_ignored", valid, 0);
        check("late_ready_speed", speed, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
